lsu_dm_master: RTL and testbench

LSU_DM_MASTER -- requirements
Module: lsu_dm_master

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_dm_master_if.sv | 31 +++
 rtl/lsu_addr_chk.sv | 31 +++
 rtl/lsu_dm_master.sv | 145 ++++++++++++++
 tb/tb_lsu_dm_master.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit data-memory master.
//   - op encodings for the CPU access type
//   - FSM state type
//   - DM_BYTES: size of the addressable data memory in bytes
//   - is_word_op(): true for 32-bit accesses (LW/SW)
package lsu_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_SW  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_SB  = 3'd4;

    localparam int unsigned DM_BYTES = 12288;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_word_op(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_dm_master_if.sv
// lsu_dm_master_if: CPU-side request/response and data-memory responder bus.
//   CPU side : req, op, addr, wdata -> ready, done, err, rdata
//   DM side  : dm_addr, dm_din, dm_we, dm_lb, dm_sb -> dm_dout
//   modport master : view of the lsu_dm_master itself
//   modport slave  : view of the surrounding CPU + memory environment
interface lsu_dm_master_if;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [13:0] dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic        dm_lb;
    logic        dm_sb;
    logic [31:0] dm_dout;

    modport master (
        input  req, op, addr, wdata, dm_dout,
        output ready, done, err, rdata, dm_addr, dm_din, dm_we, dm_lb, dm_sb
    );

    modport slave (
        output req, op, addr, wdata, dm_dout,
        input  ready, done, err, rdata, dm_addr, dm_din, dm_we, dm_lb, dm_sb
    );
endinterface

// File: rtl/lsu_addr_chk.sv
// lsu_addr_chk: combinational legality check of one CPU access.
//   in  op[2:0], addr[31:0]
//   out ok        : access may be issued to data memory
//   out err_range : access (or any byte of a word access) lies at/after DM_BYTES
//   out err_align : misaligned word access (only with LSU_ALIGN_CHECK_EN defined;
//                   otherwise tied low and misaligned words pass through)
module lsu_addr_chk
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    output logic        ok,
    output logic        err_range,
    output logic        err_align
);
    logic [32:0] w_last_byte;
    logic        w_op_legal;

    // 33-bit sum so an address near 2^32 cannot wrap back into range
    assign w_last_byte = {1'b0, addr} + (is_word_op(op) ? 33'd3 : 33'd0);
    assign err_range   = (w_last_byte >= 33'(DM_BYTES));
    assign w_op_legal  = (op <= OP_SB);

`ifdef LSU_ALIGN_CHECK_EN
    assign err_align = is_word_op(op) && (addr[1:0] != 2'b00);
`else
    assign err_align = 1'b0;
`endif

    assign ok = w_op_legal && !err_range && !err_align;
endmodule

// File: rtl/lsu_dm_master.sv
// lsu_dm_master: issues one CPU load/store at a time to the data memory.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (master)  : CPU request/response + data-memory responder signals
// Sequence per access: IDLE (accept) -> ISSUE (dm_* driven) -> DONE (done/err
// pulse) -> IDLE, so at most one access is accepted every 3 cycles.
// Optional macro LSU_ALIGN_CHECK_EN: misaligned LW/SW are rejected as errors.
// All outputs are registered; dm_* are loaded on the accept edge so they are
// valid exactly during ISSUE, and cleared again on the edge that ends ISSUE.
module lsu_dm_master
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    lsu_dm_master_if.master bus
);
    state_e      r_state;
    state_e      w_next;
    logic        w_ok;
    logic        w_err_range;
    logic        w_err_align;
    logic        w_bad;

    logic [2:0]  r_op;
    logic        r_bad;
    logic        r_ready;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [13:0] r_dm_addr;
    logic [31:0] r_dm_din;
    logic        r_dm_we;
    logic        r_dm_lb;
    logic        r_dm_sb;

    lsu_addr_chk u_chk (
        .op        (bus.op),
        .addr      (bus.addr),
        .ok        (w_ok),
        .err_range (w_err_range),
        .err_align (w_err_align)
    );

    // Individual error flags are OR-ed back in so a single faulty ok path
    // cannot let an out-of-range or misaligned write through.
    assign w_bad = !w_ok || w_err_range || w_err_align;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  begin
                if (bus.req) begin
                    w_next = ST_ISSUE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Registered outputs and captured request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= 3'd0;
            r_bad     <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_dm_addr <= 14'd0;
            r_dm_din  <= 32'd0;
            r_dm_we   <= 1'b0;
            r_dm_lb   <= 1'b0;
            r_dm_sb   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_ready <= 1'b0;
                        r_op    <= bus.op;
                        r_bad   <= w_bad;
                        // A rejected access keeps the memory bus fully quiet.
                        if (!w_bad) begin
                            r_dm_addr <= bus.addr[13:0];
                            r_dm_din  <= bus.wdata;
                            r_dm_we   <= (bus.op == OP_SW) || (bus.op == OP_SB);
                            r_dm_lb   <= (bus.op == OP_LB) || (bus.op == OP_LBU);
                            r_dm_sb   <= (bus.op == OP_SB);
                        end
                    end
                end
                ST_ISSUE: begin
                    r_dm_addr <= 14'd0;
                    r_dm_din  <= 32'd0;
                    r_dm_we   <= 1'b0;
                    r_dm_lb   <= 1'b0;
                    r_dm_sb   <= 1'b0;
                    r_done    <= 1'b1;
                    r_err     <= r_bad;
                    if (!r_bad) begin
                        // Memory already sign-extends byte reads; LBU re-zeroes.
                        case (r_op)
                            OP_LW, OP_LB: r_rdata <= bus.dm_dout;
                            OP_LBU:       r_rdata <= {24'd0, bus.dm_dout[7:0]};
                            default:      r_rdata <= r_rdata;
                        endcase
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ready <= 1'b1;
                    r_dm_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready   = r_ready;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.rdata   = r_rdata;
    assign bus.dm_addr = r_dm_addr;
    assign bus.dm_din  = r_dm_din;
    assign bus.dm_we   = r_dm_we;
    assign bus.dm_lb   = r_dm_lb;
    assign bus.dm_sb   = r_dm_sb;
endmodule

// File: tb/tb_lsu_dm_master.sv
// tb_lsu_dm_master: directed + randomized bench for lsu_dm_master with a
// byte-array data memory responder and a byte-level reference model.
module tb_lsu_dm_master;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_dm_master_if bus();

    lsu_dm_master u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0]  mem     [16384];
    logic [7:0]  ref_mem [16384];
    logic [31:0] ref_rdata;
    int          we_cnt;
    int          n_checks;
    int          n_pass;

    // Data memory responder: combinational read, byte reads sign-extended
    logic [7:0]  rd_b;
    logic [13:0] rd_a;
    always_comb begin
        rd_a = bus.dm_addr;
        rd_b = mem[rd_a];
        if (bus.dm_lb) bus.dm_dout = {{24{rd_b[7]}}, rd_b};
        else           bus.dm_dout = {mem[rd_a + 14'd3], mem[rd_a + 14'd2], mem[rd_a + 14'd1], rd_b};
    end

    // Memory init, then synchronous writes and write-cycle counting
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 7 + 3);
        we_cnt = 0;
        forever begin
            @(posedge clk);
            if (bus.dm_we && !rst) begin
                we_cnt++;
                if (bus.dm_sb) begin
                    mem[bus.dm_addr] = bus.dm_din[7:0];
                end else begin
                    mem[bus.dm_addr]          = bus.dm_din[7:0];
                    mem[bus.dm_addr + 14'd1]  = bus.dm_din[15:8];
                    mem[bus.dm_addr + 14'd2]  = bus.dm_din[23:16];
                    mem[bus.dm_addr + 14'd3]  = bus.dm_din[31:24];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [13:0] x;
        x = a[13:0];
        return {mem[x + 14'd3], mem[x + 14'd2], mem[x + 14'd1], mem[x]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [13:0] x;
        x = a[13:0];
        return {ref_mem[x + 14'd3], ref_mem[x + 14'd2], ref_mem[x + 14'd1], ref_mem[x]};
    endfunction

    // Reference model: architectural effect of one access
    task automatic model(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic exp_err);
        longint last;
        logic   word;
        logic [13:0] x;
        word = (op == 3'd0) || (op == 3'd1);
        last = longint'(addr) + (word ? 3 : 0);
        exp_err = (op > 3'd4) || (last >= 12288);
`ifdef LSU_ALIGN_CHECK_EN
        if (word && addr[1:0] != 2'b00) exp_err = 1'b1;
`endif
        x = addr[13:0];
        if (!exp_err) begin
            case (op)
                3'd0: ref_rdata = ref_word(addr);
                3'd1: begin
                    ref_mem[x]         = wdata[7:0];
                    ref_mem[x + 14'd1] = wdata[15:8];
                    ref_mem[x + 14'd2] = wdata[23:16];
                    ref_mem[x + 14'd3] = wdata[31:24];
                end
                3'd2: ref_rdata = {{24{ref_mem[x][7]}}, ref_mem[x]};
                3'd3: ref_rdata = {24'd0, ref_mem[x]};
                3'd4: ref_mem[x] = wdata[7:0];
                default: ref_rdata = ref_rdata;
            endcase
        end
    endtask

    // One access: starts just after a rising edge, ends just after one.
    task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        logic exp_err;
        logic is_store;
        int   we0;
        int   n;
        n = 0;
        while (!bus.ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_req", 32'(bus.ready), 32'd1);
        model(op, addr, wdata, exp_err);
        is_store = !exp_err && (op == 3'd1 || op == 3'd4);
        we0 = we_cnt;
        bus.req = 1'b1; bus.op = op; bus.addr = addr; bus.wdata = wdata;
        @(posedge clk); #1;
        // Scramble inputs: the unit must work from its captured copies.
        bus.req = 1'b0; bus.op = 3'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
        check("ready_in_issue", 32'(bus.ready), 32'd0);
        check("done_in_issue", 32'(bus.done), 32'd0);
        check("we_in_issue", 32'(bus.dm_we), 32'(is_store));
        @(posedge clk); #1;
        check("done_pulse", 32'(bus.done), 32'd1);
        check("err_pulse", 32'(bus.err), 32'(exp_err));
        check("ready_in_done", 32'(bus.ready), 32'd0);
        @(posedge clk); #1;
        check("done_cleared", 32'(bus.done), 32'd0);
        check("err_cleared", 32'(bus.err), 32'd0);
        check("rdata", bus.rdata, ref_rdata);
        check("we_cycles", 32'(we_cnt - we0), 32'(is_store));
        check("mem_word", mem_word(addr), ref_word(addr));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int accepts;
        int last_acc;
        int bad_bytes;
        logic [2:0]  r_op;
        logic [31:0] r_addr;
        int sel;

        n_checks = 0; n_pass = 0;
        ref_rdata = 32'd0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 8'(i * 7 + 3);
        rst = 1'b1;
        bus.req = 1'b0; bus.op = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
        #12;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_dm_we", 32'(bus.dm_we), 32'd0);
        check("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Word store then load
        do_txn(3'd1, 32'h10, 32'hDEADBEEF);
        do_txn(3'd0, 32'h10, 32'h0);
        check("lw_deadbeef", bus.rdata, 32'hDEADBEEF);

        // Byte store, signed and unsigned byte load
        do_txn(3'd4, 32'h21, 32'h000000F0);
        do_txn(3'd2, 32'h21, 32'h0);
        check("lb_sext", bus.rdata, 32'hFFFFFFF0);
        do_txn(3'd3, 32'h21, 32'h0);
        check("lbu_zext", bus.rdata, 32'h000000F0);

        // Word crossing the memory limit, illegal op, last legal byte/word
        do_txn(3'd0, 32'h2FFE, 32'h0);
        check("lw_cross_keeps_rdata", bus.rdata, 32'h000000F0);
        do_txn(3'd1, 32'h2FFE, 32'h11223344);
        do_txn(3'd6, 32'h20, 32'h55667788);
        do_txn(3'd4, 32'h2FFF, 32'h000000AB);
        do_txn(3'd1, 32'h2FFC, 32'hCAFEF00D);
        do_txn(3'd4, 32'h3000, 32'h000000CD);

        // Misaligned word store
        do_txn(3'd1, 32'h13, 32'hA5A55A5A);
        do_txn(3'd0, 32'h13, 32'h0);

        // Reset during ISSUE of a store
        bus.req = 1'b1; bus.op = 3'd1; bus.addr = 32'h40; bus.wdata = 32'h12345678;
        sel = we_cnt;
        @(posedge clk); #1;
        bus.req = 1'b0;
        check("abort_we_before_rst", 32'(bus.dm_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_dm_we", 32'(bus.dm_we), 32'd0);
        check("abort_dm_din", bus.dm_din, 32'd0);
        check("abort_rdata", bus.rdata, 32'd0);
        ref_rdata = 32'd0;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("abort_mem40", mem_word(32'h40), ref_word(32'h40));
        check("abort_no_write", 32'(we_cnt - sel), 32'd0);
        check("abort_ready_after", 32'(bus.ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);

        // Randomized accesses
        for (int k = 0; k < 60; k++) begin
            r_op = 3'($urandom_range(0, 7));
            sel  = $urandom_range(0, 9);
            if (sel == 0)      r_addr = $urandom;
            else if (sel == 1) r_addr = 32'(12280 + $urandom_range(0, 10));
            else if (sel < 5)  r_addr = 32'($urandom_range(0, 63));
            else               r_addr = 32'($urandom_range(0, 12287));
            do_txn(r_op, r_addr, $urandom);
        end

        // Continuous request stream: one accept every third cycle
        accepts = 0; last_acc = -1;
        bus.req = 1'b1; bus.op = 3'd0; bus.addr = 32'h10; bus.wdata = 32'd0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("stream_ready", 32'(bus.ready), 32'((i % 3) == 0));
            if (bus.ready) begin
                if (last_acc >= 0) check("stream_gap", 32'(i - last_acc), 32'd3);
                last_acc = i;
                accepts++;
            end
        end
        bus.req = 1'b0;
        @(posedge clk); #1;
        check("stream_accepts", 32'(accepts), 32'd10);
        ref_rdata = ref_word(32'h10);
        check("stream_rdata", bus.rdata, ref_rdata);
        check("stream_ready_end", 32'(bus.ready), 32'd1);

        // Whole-memory comparison against the reference
        bad_bytes = 0;
        for (int i = 0; i < 16384; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
        check("mem_all_bytes", 32'(bad_bytes), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
